// File: rtl/mem_access.sv
// Memory-access stage: turns load/store ops from EX/MEM into single-beat
// data-bus transactions. It stalls the pipeline while a transaction is in
// flight and hands the result on to the MEM/WB register.
//
// Bus handshake: bus_req rises on the edge after a valid load/store is seen
// in IDLE. bus_we/bus_addr/bus_wdata/bus_sel are registered at that same
// edge and stay frozen while bus_req=1. The slave completes the access with
// a one-cycle bus_ack, and bus_rdata is valid in that cycle. bus_req drops on
// the following edge. An ack seen outside REQ has no effect.
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic [1:0]  mem_excp,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_SW  = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rdata_q, rdata_d;

  logic        op_is_ld, op_is_st, misalign, start;
  logic        op_q_is_ld;
  logic [7:0]  lane_byte;
  logic [31:0] load_val;
  logic [4:0]  stall_unused;

  // Only the MEM/WB hold bit of the stall vector matters here.
  assign stall_unused = {stall[5], stall[3:0]};

  // Decode the incoming op. Codes 6-7 fall through as NONE.
  always_comb begin
    op_is_ld = (mem_op == OP_LW) || (mem_op == OP_LB) || (mem_op == OP_LBU);
    op_is_st = (mem_op == OP_SW) || (mem_op == OP_SB);
    misalign = ((mem_op == OP_LW) || (mem_op == OP_SW)) && (mem_addr[1:0] != 2'b00);
    start    = (op_is_ld || op_is_st) && !misalign;
  end

  // Extract the addressed byte lane (little-endian) and form the load result.
  always_comb begin
    lane_byte = 8'h00;
    load_val  = bus_rdata;
    case (lane_q)
      2'd0:    lane_byte = bus_rdata[7:0];
      2'd1:    lane_byte = bus_rdata[15:8];
      2'd2:    lane_byte = bus_rdata[23:16];
      default: lane_byte = bus_rdata[31:24];
    endcase
    if (op_q == OP_LB) begin
      load_val = {{24{lane_byte[7]}}, lane_byte};
    end else if (op_q == OP_LBU) begin
      load_val = {24'h000000, lane_byte};
    end
  end

  // Next-state logic: launch in IDLE, wait for ack or timeout in REQ,
  // hold results in DONE until the MEM/WB stage stops stalling.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    op_d        = op_q;
    lane_d      = lane_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = REQ;
          bus_req_d  = 1'b1;
          bus_we_d   = op_is_st;
          bus_addr_d = {mem_addr[31:2], 2'b00};
          if (mem_op == OP_SB) begin
            bus_sel_d   = 4'b0001 << mem_addr[1:0];
            bus_wdata_d = {4{mem_sdata[7:0]}};
          end else begin
            bus_sel_d   = 4'b1111;
            bus_wdata_d = mem_sdata;
          end
          op_d      = mem_op;
          lane_d    = mem_addr[1:0];
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          rdata_d   = load_val;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (!stall[4]) begin
          state_d   = IDLE;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bus registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_sel_q   <= 4'h0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      op_q        <= 3'd0;
      lane_q      <= 2'd0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      rdata_q     <= rdata_d;
    end
  end

  assign op_q_is_ld = (op_q == OP_LW) || (op_q == OP_LB) || (op_q == OP_LBU);

  // Writeback, stall and exception outputs; all forced quiet during reset.
  always_comb begin
    wb_wd    = mem_wd;
    wb_wreg  = 1'b0;
    wb_wdata = mem_wdata;
    stallreq = 1'b0;
    mem_excp = 2'b00;
    if (!rst) begin
      wb_wd    = 5'd0;
      wb_wdata = 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          stallreq    = start;
          mem_excp[0] = misalign;
          wb_wreg     = !(op_is_ld || op_is_st) && mem_wreg;
        end
        REQ: begin
          stallreq = 1'b1;
        end
        DONE: begin
          mem_excp[1] = timeout_q;
          if (op_q_is_ld && !timeout_q) begin
            wb_wreg  = 1'b1;
            wb_wdata = rdata_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_sel   = bus_sel_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles waiting for bus_ack before abort.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 stall  input  6  pipeline stall vector from ctrl; bit 4 = MEM/WB hold (1 = Stop).
REQ-005 mem_wd  input  5  destination register address from EX/MEM.
REQ-006 mem_wreg  input  1  write-enable from EX/MEM.
REQ-007 mem_wdata  input  32  ALU result from EX/MEM.
REQ-008 mem_op  input  3  0 NONE, 1 LW, 2 SW, 3 LB, 4 LBU, 5 SB; 6-7 treated as NONE.
REQ-009 mem_addr  input  32  effective address; mem_sdata  input  32  store data.
REQ-010 bus_req  output  1  registered request to data bus.
REQ-011 bus_we  output  1; bus_addr  output  32 (word-aligned); bus_wdata  output  32; bus_sel  output  4; all registered, valid while bus_req=1.
REQ-012 bus_ack  input  1  one-cycle completion pulse; bus_rdata  input  32  valid with bus_ack.
REQ-013 wb_wd  output  5; wb_wreg  output  1; wb_wdata  output  32  to MEM/WB register.
REQ-014 stallreq  output  1  stall request to ctrl.
REQ-015 mem_excp  output  2  bit0 misaligned address, bit1 bus timeout.

Function
REQ-016 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-017 IDLE, mem_op NONE: wb_* = mem_wd/mem_wreg/mem_wdata combinationally, stallreq=0, no bus activity.
REQ-018 IDLE, LW/SW with mem_addr[1:0]!=0: no bus request, stallreq=0, wb_wreg=0, mem_excp[0]=1 same cycle.
REQ-019 IDLE, valid load/store: stallreq=1 combinationally; next edge -> REQ with bus_req=1, bus_addr={mem_addr[31:2],2'b00}.
REQ-020 LW/LB/LBU: bus_we=0, bus_sel=4'b1111; SW: bus_we=1, sel=4'b1111, wdata=mem_sdata; SB: bus_we=1, sel=1<<mem_addr[1:0], wdata=mem_sdata[7:0] replicated x4.
REQ-021 REQ: stallreq=1; cycle counter increments each cycle bus_ack=0.
REQ-022 REQ with bus_ack=1: next edge -> DONE, bus_req=0, load result captured.
REQ-023 Byte lanes little-endian: addr[1:0]=0 selects rdata[7:0] ... 3 selects rdata[31:24]; LB sign-extends, LBU zero-extends.
REQ-024 REQ, counter reaches TIMEOUT-1 with no ack: next edge -> DONE, bus_req=0, timeout flag set.
REQ-025 DONE: stallreq=0; wb_wd=mem_wd; loads: wb_wreg=1, wb_wdata=captured value; stores: wb_wreg=0; timeout: wb_wreg=0, mem_excp[1]=1.
REQ-026 DONE with stall[4]=Stop: remain DONE, outputs held; stall[4]=NoStop: next edge -> IDLE, flags cleared.
REQ-027 Minimum load/store latency: 3 cycles (IDLE, REQ with ack in first REQ cycle, DONE).
REQ-028 bus_ack while not in REQ ignored.
REQ-029 bus_addr/bus_wdata/bus_sel/bus_we stable for entire REQ residency.

Reset
REQ-030 rst low: immediately (asynchronously) state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_sel=0, counter=0, flags=0.
REQ-031 While rst low: wb_wd=0, wb_wreg=0, wb_wdata=0, stallreq=0, mem_excp=0.
REQ-032 Reset asserted in REQ aborts transaction; a late bus_ack after release is ignored.

Verification
REQ-033 mem_op=NONE, mem_wd=5, mem_wreg=1, mem_wdata=0x1234 -> wb_* = 5/1/0x1234 same cycle, stallreq=0.
REQ-034 LW addr 0x100, ack after 2 REQ cycles with rdata 0xDEADBEEF -> bus_addr=0x100, stallreq high 3 cycles, DONE wb_wdata=0xDEADBEEF, wb_wreg=1.
REQ-035 LB addr 0x103, rdata 0x80FF0011 -> wb_wdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SB addr 0x202, sdata 0xAB -> bus_sel=4'b0100, bus_wdata=0xABABABAB, bus_we=1, DONE wb_wreg=0.
REQ-037 LW addr 0x102 -> no bus_req, mem_excp=2'b01, wb_wreg=0; LW with no ack -> bus_req drops after 16 REQ cycles, mem_excp=2'b10.
REQ-038 rst low mid-REQ -> bus_req=0 immediately, state IDLE; DONE with stall[4]=Stop for 3 cycles -> outputs held, then IDLE.
